mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: XLEN, default 32, data/address width; DATA_BASE, default 32'h8000_0000, ORed into every data address; TIMEOUT, default 15, maximum cycles to wait for mem_ready; DATA_FIRST, default 1, meaning data wins when data and fetch request together.
REQ-002 SHALL have ports:
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high reset.
- if_req / if_addr, in, 1 / XLEN: fetch request, held until if_valid.
- if_rdata / if_valid, out, XLEN / 1: fetched word; if_valid is a one-cycle completion pulse.
- d_req / d_we, in, 1 / 1: data request, held until d_valid; d_we=1 means store.
- d_funct3, in, 3: RV32 load/store width code.
- d_addr / d_wdata, in, XLEN / XLEN: data address and store data.
- d_rdata / d_valid / d_err, out, XLEN / 1 / 1: extended load data; completion pulse; error pulse.
- mem_addr / mem_wdata, out, XLEN / XLEN: bus address and bus write data.
- mem_re / mem_we, out, 1 / 1: bus read and write strobes.
- mem_be, out, XLEN/8: byte enables.
- mem_rdata / mem_ready, in, XLEN / 1: bus read data and completion.
- stall, out, 1: pipeline hold request.

Function
REQ-003 SHALL implement FSM IDLE, DATA, FETCH; state is registered, outputs are decoded from state plus latched request.
REQ-004 IDLE: d_req (DATA_FIRST=1 or no if_req) -> DATA; else if_req -> FETCH; both -> DATA when DATA_FIRST=1, FETCH otherwise.
REQ-005 On entering DATA or FETCH, SHALL latch address, funct3, we and wdata; later input changes SHALL be ignored until completion.
REQ-006 In DATA, SHALL drive mem_addr = latched d_addr | DATA_BASE, assert mem_we or mem_re, and drive mem_be per REQ-009.
REQ-007 In FETCH, SHALL drive mem_addr = if_addr, assert mem_re, and drive mem_be all ones.
REQ-008 Completion: on a cycle with mem_ready=1 in DATA/FETCH, SHALL register the result and pulse d_valid/if_valid in the next cycle, then return to IDLE; minimum latency is 2 cycles from req to valid.
REQ-009 Byte lanes, with ofs = addr[1:0]:
- 000 (SB/LB) and 100 (LBU): byte lane ofs.
- 001 (SH/LH) and 101 (LHU): lanes ofs and ofs+1, ofs even.
- 010 (SW/LW): all lanes, ofs=0.
- Store data is replicated across lanes.
REQ-010 Load extension: select byte/half at ofs; 000/001 sign-extend, 100/101 zero-extend, 010 pass through.
REQ-011 Misaligned access (half with ofs odd, word with ofs!=0) or illegal funct3 (011, 110, 111): no bus strobe; d_err and d_valid SHALL pulse together one cycle after latching; d_rdata=0.
REQ-012 Timeout: the wait counter SHALL reset on entering DATA/FETCH; if mem_ready has not been seen after TIMEOUT cycles, SHALL drop strobes, pulse the respective valid with d_err=1 (data) or if_rdata=32'h0000_0013 NOP (fetch), and go IDLE.
REQ-013 stall SHALL be 1 whenever d_req or if_req is high without its valid pulse in the same cycle.
REQ-014 A request still held during its valid cycle SHALL NOT be re-issued; a new transaction needs req low for one cycle or a changed address.
REQ-015 mem_re and mem_we SHALL never be high simultaneously.

Reset
REQ-016 While reset is high, SHALL hold state IDLE, counter 0, all strobes/valid/err 0, if_rdata 0, d_rdata 0, mem_addr 0, mem_be 0.
REQ-017 Reset mid-transaction SHALL abandon it immediately with no valid pulse; the first request is accepted in the cycle after reset deasserts.

Structure
REQ-018 State enum, funct3 codes, NOP constant and DATA_BASE default SHALL live in shared package mem_pkg.
REQ-019 Lane select and extension SHALL be one combinational sub-module, mem_lane_unit, instanced once.

Verification
REQ-020 LW at 0x10, mem returns 0xDEADBEEF on first cycle: mem_addr=0x8000_0010, mem_be=1111, d_valid on cycle 2, d_rdata=0xDEADBEEF.
REQ-021 LB at 0x13, memory word 0x80FF_0000: mem_be=1000, d_rdata=0xFFFF_FF80; LBU at the same address gives 0x0000_0080.
REQ-022 SH 0x1234 at 0x6: mem_we=1, mem_be=1100, mem_wdata=0x1234_1234; LH at 0x5: no strobe, d_err=1.
REQ-023 if_req and d_req together, DATA_FIRST=1: data completes first, then fetch; stall stays high until if_valid.
REQ-024 mem_ready held 0 on fetch: after 15 cycles, if_valid=1, if_rdata=0x0000_0013, state IDLE.
REQ-025 Reset asserted in DATA with the counter at 5: strobes drop asynchronously, no d_valid; a request issued after reset completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory port arbiter and its byte-lane unit.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSN          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h8000_0000;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane enables, store replication, load extension and alignment check for RV32 accesses.
module mem_lane_unit
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        ofs,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   load_data,
  output logic              err
);

  localparam int BW = XLEN / 8;

  logic [XLEN-1:0] shifted;

  // funct3[2] marks the unsigned load variants, so it gates the sign bit.
  always_comb begin
    shifted   = rdata >> {ofs, 3'b000};
    be        = '0;
    wdata_rep = '0;
    load_data = '0;
    err       = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = BW'(1) << ofs;
        wdata_rep = {(XLEN/8){wdata[7:0]}};
        load_data = {{(XLEN-8){shifted[7] & ~funct3[2]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        err       = ofs[0];
        be        = ofs[0] ? '0 : (BW'(3) << ofs);
        wdata_rep = {(XLEN/16){wdata[15:0]}};
        load_data = {{(XLEN-16){shifted[15] & ~funct3[2]}}, shifted[15:0]};
      end
      F3_W: begin
        err       = (ofs != 2'b00);
        be        = (ofs != 2'b00) ? '0 : '1;
        wdata_rep = wdata;
        load_data = rdata;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory bus, with timeout and error reporting.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] DATA_BASE  = DEFAULT_DATA_BASE,
  parameter int              TIMEOUT    = 15,
  parameter int              DATA_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              stall
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [2:0]        lat_funct3;
  logic              lat_we;
  logic              d_hold;
  logic              if_hold;
  logic [XLEN-1:0]   d_last;
  logic [XLEN-1:0]   if_last;

  logic [XLEN/8-1:0] lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_load;
  logic              lane_err;
  logic              d_ok;
  logic              if_ok;
  logic              timeout_hit;

  mem_lane_unit #(.XLEN(XLEN)) u_lane (
    .funct3    (lat_funct3),
    .ofs       (lat_addr[1:0]),
    .wdata     (lat_wdata),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .load_data (lane_load),
    .err       (lane_err)
  );

  // A request that just completed stays blocked until it drops or changes address.
  assign d_ok        = d_req  && !(d_hold  && (d_addr  == d_last));
  assign if_ok       = if_req && !(if_hold && (if_addr == if_last));
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign stall       = (d_req && !d_valid) || (if_req && !if_valid);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    case (state)
      ST_DATA: begin
        mem_addr = lat_addr | DATA_BASE;
        if (!lane_err) begin
          mem_be = lane_be;
          mem_we = lat_we;
          mem_re = !lat_we;
          if (lat_we) mem_wdata = lane_wdata;
        end
      end
      ST_FETCH: begin
        mem_addr = lat_addr;
        mem_re   = 1'b1;
        mem_be   = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      lat_we     <= 1'b0;
      d_hold     <= 1'b0;
      if_hold    <= 1'b0;
      d_last     <= '0;
      if_last    <= '0;
      d_valid    <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
    end else begin
      d_valid  <= 1'b0;
      d_err    <= 1'b0;
      if_valid <= 1'b0;
      if (!d_req  || (d_addr  != d_last))  d_hold  <= 1'b0;
      if (!if_req || (if_addr != if_last)) if_hold <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (d_ok && ((DATA_FIRST != 0) || !if_ok)) begin
            state      <= ST_DATA;
            lat_addr   <= d_addr;
            lat_funct3 <= d_funct3;
            lat_we     <= d_we;
            lat_wdata  <= d_wdata;
          end else if (if_ok) begin
            state      <= ST_FETCH;
            lat_addr   <= if_addr;
            lat_funct3 <= F3_W;
            lat_we     <= 1'b0;
          end
        end
        ST_DATA: begin
          if (lane_err || mem_ready || timeout_hit) begin
            state   <= ST_IDLE;
            d_valid <= 1'b1;
            d_hold  <= 1'b1;
            d_last  <= lat_addr;
            d_err   <= lane_err || !mem_ready;
            d_rdata <= (lane_err || !mem_ready || lat_we) ? '0 : lane_load;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FETCH: begin
          if (mem_ready || timeout_hit) begin
            state    <= ST_IDLE;
            if_valid <= 1'b1;
            if_hold  <= 1'b1;
            if_last  <= lat_addr;
            if_rdata <= mem_ready ? mem_rdata : XLEN'(NOP_INSN);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs are checked on the falling edge.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_funct3  (d_funct3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.state); end
    checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_strobes got re=%b we=%b exp 0/0", mem_re, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0) begin failures++; $display("FAIL rst_addr_be got addr=%h be=%b exp 0/0", mem_addr, mem_be); end
    checks++; if (d_valid !== 1'b0 || if_valid !== 1'b0 || d_err !== 1'b0) begin failures++; $display("FAIL rst_valid got dv=%b iv=%b de=%b exp 0", d_valid, if_valid, d_err); end
    checks++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got d=%h i=%h exp 0", d_rdata, if_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_lw;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10;
    mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall_pending got=%b exp=1", stall); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h8000_0010) begin failures++; $display("FAIL lw_addr got=%h exp=80000010", mem_addr); end
    checks++; if (mem_be !== 4'b1111 || mem_re !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL lw_bus got be=%b re=%b we=%b exp 1111/1/0", mem_be, mem_re, mem_we); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_err !== 1'b0) begin failures++; $display("FAIL lw_valid got v=%b e=%b exp 1/0", d_valid, d_err); end
    checks++; if (d_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", d_rdata); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lw_stall_done got=%b exp=0", stall); end
    d_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_lb_lbu;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b000; d_addr = 32'h13;
    mem_rdata = 32'h80FF_0000; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_be !== 4'b1000 || mem_addr !== 32'h8000_0013) begin failures++; $display("FAIL lb_bus got be=%b addr=%h exp 1000/80000013", mem_be, mem_addr); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got v=%b d=%h exp 1/ffffff80", d_valid, d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_funct3 = 3'b100;
    repeat (2) @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_rdata got v=%b d=%h exp 1/00000080", d_valid, d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_half_and_errors;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b001; d_addr = 32'h6; d_wdata = 32'h0000_1234;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_be !== 4'b1100) begin failures++; $display("FAIL sh_bus got we=%b re=%b be=%b exp 1/0/1100", mem_we, mem_re, mem_be); end
    checks++; if (mem_wdata !== 32'h1234_1234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", mem_wdata); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_err !== 1'b0) begin failures++; $display("FAIL sh_valid got v=%b e=%b exp 1/0", d_valid, d_err); end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_funct3 = 3'b101; d_addr = 32'h6; mem_rdata = 32'h80FF_0000;
    repeat (2) @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h0000_80FF) begin failures++; $display("FAIL lhu_rdata got v=%b d=%h exp 1/000080ff", d_valid, d_rdata); end
    d_req = 1'b0;
    // Odd half address: no strobe, error pulse together with valid, and zero data.
    @(negedge clk);
    d_req = 1'b1; d_funct3 = 3'b001; d_addr = 32'h5;
    @(negedge clk);
    checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL lh_mis_strobe got re=%b we=%b exp 0/0", mem_re, mem_we); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL lh_mis_err got v=%b e=%b d=%h exp 1/1/0", d_valid, d_err, d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_funct3 = 3'b011; d_addr = 32'h0;
    @(negedge clk);
    checks++; if (mem_re !== 1'b0 || mem_be !== 4'b0000) begin failures++; $display("FAIL illegal_strobe got re=%b be=%b exp 0/0000", mem_re, mem_be); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_err !== 1'b1) begin failures++; $display("FAIL illegal_err got v=%b e=%b exp 1/1", d_valid, d_err); end
    d_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_priority;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h100;
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h8000_0020 || mem_re !== 1'b1) begin failures++; $display("FAIL prio_data_first got addr=%h re=%b exp 80000020/1", mem_addr, mem_re); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL prio_stall_a got=%b exp=1", stall); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== 32'h1111_1111) begin failures++; $display("FAIL prio_data_done got dv=%b iv=%b d=%h exp 1/0/11111111", d_valid, if_valid, d_rdata); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL prio_stall_b got=%b exp=1", stall); end
    d_req = 1'b0; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0000_0100 || mem_be !== 4'b1111 || mem_re !== 1'b1) begin failures++; $display("FAIL prio_fetch_bus got addr=%h be=%b re=%b exp 00000100/1111/1", mem_addr, mem_be, mem_re); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL prio_stall_c got=%b exp=1", stall); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || stall !== 1'b0) begin failures++; $display("FAIL prio_fetch_done got iv=%b i=%h st=%b exp 1/00500093/0", if_valid, if_rdata, stall); end
    if_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_no_reissue;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h30;
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    repeat (2) @(negedge clk);
    checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL reissue_first got v=%b exp 1", d_valid); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (mem_re !== 1'b0 || d_valid !== 1'b0) begin failures++; $display("FAIL reissue_held got re=%b v=%b exp 0/0", mem_re, d_valid); end
    end
    d_addr = 32'h34;
    @(negedge clk);
    checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h8000_0034) begin failures++; $display("FAIL reissue_new_addr got re=%b addr=%h exp 1/80000034", mem_re, mem_addr); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL reissue_done got v=%b d=%h exp 1/0badf00d", d_valid, d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int waited = 0;
    int re_cycles = 0;
    bit seen = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200; mem_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (if_valid) begin seen = 1'b1; waited = i; break; end
      if (mem_re) re_cycles++;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL fetch_timeout_seen got=%b exp=1 (no if_valid in 40 cycles)", seen); end
    checks++; if (waited != 16 || re_cycles != 15) begin failures++; $display("FAIL fetch_timeout_len got valid_at=%0d re_cycles=%0d exp 16/15", waited, re_cycles); end
    checks++; if (if_rdata !== 32'h0000_0013) begin failures++; $display("FAIL fetch_timeout_nop got=%h exp=00000013", if_rdata); end
    checks++; if (dut.state !== ST_IDLE || mem_re !== 1'b0) begin failures++; $display("FAIL fetch_timeout_idle got state=%0d re=%b exp 0/0", dut.state, mem_re); end
    if_req = 1'b0;
  endtask

  task automatic test_data_timeout;
    int waited = 0;
    int we_cycles = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h8; d_wdata = 32'hA5A5_A5A5;
    mem_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (d_valid) begin waited = i; break; end
      if (mem_we) we_cycles++;
    end
    checks++; if (waited != 16 || we_cycles != 15) begin failures++; $display("FAIL data_timeout_len got valid_at=%0d we_cycles=%0d exp 16/15", waited, we_cycles); end
    checks++; if (d_err !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL data_timeout_err got e=%b we=%b exp 1/0", d_err, mem_we); end
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h40; mem_ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (dut.cnt !== 4'd5 || mem_re !== 1'b1) begin failures++; $display("FAIL midrst_setup got cnt=%0d re=%b exp 5/1", dut.cnt, mem_re); end
    reset = 1'b1; d_req = 1'b0;
    #1;
    checks++; if (mem_re !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin failures++; $display("FAIL midrst_async got re=%b addr=%h be=%b exp 0/0/0", mem_re, mem_addr, mem_be); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_valid_a got=%b exp=0", d_valid); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (d_valid !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL midrst_no_valid_b got v=%b re=%b exp 0/0", d_valid, mem_re); end
    d_req = 1'b1; d_addr = 32'h44; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h8000_0044 || mem_re !== 1'b1) begin failures++; $display("FAIL midrst_new_bus got addr=%h re=%b exp 80000044/1", mem_addr, mem_re); end
    @(negedge clk);
    checks++; if (d_valid !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL midrst_new_done got v=%b d=%h exp 1/cafef00d", d_valid, d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_half_and_errors();
    test_priority();
    test_no_reissue();
    test_timeout();
    test_data_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
